axis_insert_header: RTL and testbench

- AXI-Stream header inserter. Prepends a variable-length header (0..DATA_BYTE_WD bytes) to each data packet.
- Outputs the concatenated byte stream, repacked into full beats, with a left-aligned partial final beat.
- Sits between a packet source and a downstream AXI-Stream sink; one header is consumed per packet.

---
 rtl/axis_insert_header.sv | 239 +++++++++++++++++++++++
 tb/tb_axis_insert_header.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_insert_header.sv
// AXI-Stream header inserter: prepends 0..DATA_BYTE_WD header bytes to each packet and repacks into full beats.
// Define OUT_SKID_EN for a 2-entry output skid buffer with a registered ready_in.
module axis_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int NB  = DATA_BYTE_WD;
  localparam int CW  = $clog2(NB + 1);
  localparam int SW  = CW + 1;
  localparam int SHW = $clog2(DATA_WD + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic [DATA_WD-1:0] res_reg, res_next;
  logic [CW-1:0]      res_cnt_reg, res_cnt_next;

  logic [DATA_WD-1:0]   data_in_m, data_insert_m, hdr_left;
  logic [2*DATA_WD-1:0] cat;
  logic [CW-1:0]        k_cnt, hdr_cnt;
  logic [SW-1:0]        sum;
  logic [SHW-1:0]       hdr_shift, res_shift;
  logic                 res_full, sum_ge, sum_gt;
  logic                 emit_ok, in_fire, hdr_fire;

  logic                 beat_valid, beat_last;
  logic [DATA_WD-1:0]   beat_data;
  logic [NB-1:0]        beat_keep;

  // keep_insert alone defines the header length; the count input is informational.
  logic unused_cnt;
  assign unused_cnt = ^byte_insert_cnt;

  function automatic logic [CW-1:0] popcnt(input logic [NB-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < NB; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic logic [NB-1:0] top_mask(input logic [SW-1:0] n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[NB-1-i] = (SW'(i) < n);
    return m;
  endfunction

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign data_in_m[gi*8 +: 8]     = keep_in[gi]     ? data_in[gi*8 +: 8]     : 8'h00;
      assign data_insert_m[gi*8 +: 8] = keep_insert[gi] ? data_insert[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Residual bytes are kept left-aligned so new bytes simply shift in behind them.
  assign k_cnt     = popcnt(keep_in);
  assign hdr_cnt   = popcnt(keep_insert);
  assign sum       = SW'(res_cnt_reg) + SW'(k_cnt);
  assign hdr_shift = SHW'(8 * (NB - int'(hdr_cnt)));
  assign res_shift = SHW'(8 * int'(res_cnt_reg));
  assign hdr_left  = data_insert_m << hdr_shift;
  assign cat       = {res_reg, {DATA_WD{1'b0}}} | ({data_in_m, {DATA_WD{1'b0}}} >> res_shift);
  assign res_full  = (res_cnt_reg == CW'(NB));
  assign sum_ge    = (sum >= SW'(NB));
  assign sum_gt    = (sum >  SW'(NB));

  assign ready_in     = !rst && (state_reg == S_DATA) && !res_full && emit_ok;
  assign ready_insert = !rst && (state_reg == S_IDLE) && !valid_out;
  assign in_fire      = valid_in && ready_in;
  assign hdr_fire     = valid_insert && ready_insert;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      res_reg     <= '0;
      res_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      res_reg     <= res_next;
      res_cnt_reg <= res_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (hdr_fire) state_next = S_DATA;
      S_DATA:  if (in_fire && last_in) state_next = sum_gt ? S_FLUSH : S_IDLE;
      S_FLUSH: if (emit_ok) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    beat_valid   = 1'b0;
    beat_data    = '0;
    beat_keep    = '0;
    beat_last    = 1'b0;
    res_next     = res_reg;
    res_cnt_next = res_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (hdr_fire) begin
          res_next     = hdr_left;
          res_cnt_next = hdr_cnt;
        end
      end
      S_DATA: begin
        if (res_full && emit_ok) begin
          // A full-width header goes out on its own before any data is taken.
          beat_valid   = 1'b1;
          beat_data    = res_reg;
          beat_keep    = '1;
          res_next     = '0;
          res_cnt_next = '0;
        end else if (in_fire) begin
          if (last_in && !sum_gt) begin
            beat_valid   = 1'b1;
            beat_data    = cat[2*DATA_WD-1 -: DATA_WD];
            beat_keep    = top_mask(sum);
            beat_last    = 1'b1;
            res_next     = '0;
            res_cnt_next = '0;
          end else if (sum_ge) begin
            beat_valid   = 1'b1;
            beat_data    = cat[2*DATA_WD-1 -: DATA_WD];
            beat_keep    = '1;
            res_next     = cat[DATA_WD-1:0];
            res_cnt_next = CW'(sum - SW'(NB));
          end else begin
            res_next     = cat[2*DATA_WD-1 -: DATA_WD];
            res_cnt_next = CW'(sum);
          end
        end
      end
      S_FLUSH: begin
        if (emit_ok) begin
          beat_valid   = 1'b1;
          beat_data    = res_reg;
          beat_keep    = top_mask(SW'(res_cnt_reg));
          beat_last    = 1'b1;
          res_next     = '0;
          res_cnt_next = '0;
        end
      end
      default: ;
    endcase
  end

`ifdef OUT_SKID_EN
  logic [DATA_WD-1:0] mem_data [2];
  logic [NB-1:0]      mem_keep [2];
  logic               mem_last [2];
  logic               wr_ptr_reg, rd_ptr_reg, can_push_reg;
  logic [1:0]         cnt_reg, cnt_next;
  logic               push, pop;

  assign push     = beat_valid;
  assign pop      = valid_out && ready_out;
  assign cnt_next = cnt_reg + 2'(push) - 2'(pop);
  assign emit_ok  = can_push_reg;

  // Space is granted one cycle ahead, so ready_in never sees ready_out combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      cnt_reg      <= '0;
      can_push_reg <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_keep[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr_reg] <= beat_data;
        mem_keep[wr_ptr_reg] <= beat_keep;
        mem_last[wr_ptr_reg] <= beat_last;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      cnt_reg      <= cnt_next;
      can_push_reg <= (cnt_next < 2'd2);
    end
  end

  assign valid_out = (cnt_reg != 2'd0);
  assign data_out  = valid_out ? mem_data[rd_ptr_reg] : '0;
  assign keep_out  = valid_out ? mem_keep[rd_ptr_reg] : '0;
  assign last_out  = valid_out && mem_last[rd_ptr_reg];
`else
  logic               valid_out_reg, last_out_reg;
  logic [DATA_WD-1:0] data_out_reg;
  logic [NB-1:0]      keep_out_reg;

  assign emit_ok = !valid_out_reg || ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      last_out_reg  <= 1'b0;
    end else if (emit_ok) begin
      valid_out_reg <= beat_valid;
      data_out_reg  <= beat_data;
      keep_out_reg  <= beat_keep;
      last_out_reg  <= beat_last;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign keep_out  = keep_out_reg;
  assign last_out  = last_out_reg;
`endif

endmodule

// File: tb/tb_axis_insert_header.sv
// Directed self-checking bench for axis_insert_header: header lengths 0..4, early data, stalls, empty last beats, reset.
module tb_axis_insert_header;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0, last_in = 1'b0, ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        valid_out, last_out, ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_insert = 1'b0, ready_insert;
  logic [31:0] data_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [1:0]  byte_insert_cnt = '0;

  axis_insert_header dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: one entry {last, keep, data} per handshaken beat.
  logic [36:0] q_out[$];
  int          q_cyc[$];
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      q_out.push_back({last_out, keep_out, data_out});
      q_cyc.push_back(cyc);
    end
  end

  logic [31:0] pd[8];
  logic [3:0]  pk[8];
  int          pn;
  logic [31:0] ed[8];
  logic [3:0]  ek[8];
  logic        el[8];
  int          en;
  int          first_acc;
  bit          s5_done = 1'b0;

  task automatic set_in(input int i, input logic [31:0] d, input logic [3:0] k);
    pd[i] = d; pk[i] = k; pn = i + 1;
  endtask

  task automatic set_exp(input int i, input logic [31:0] d, input logic [3:0] k, input logic l);
    ed[i] = d; ek[i] = k; el[i] = l; en = i + 1;
  endtask

  task automatic send_header(input logic [31:0] d, input logic [3:0] k);
    bit fired;
    fired = 1'b0;
    data_insert = d; keep_insert = k; byte_insert_cnt = 2'($countones(k)); valid_insert = 1'b1;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      if (ready_insert) fired = 1'b1;
      @(posedge clk); #1;
    end
    valid_insert = 1'b0;
    if (!fired) check("hdr_timeout", 0, 1);
  endtask

  task automatic send_pkt();
    bit fired;
    for (int b = 0; b < pn; b++) begin
      valid_in = 1'b1; data_in = pd[b]; keep_in = pk[b]; last_in = (b == pn - 1);
      fired = 1'b0;
      for (int i = 0; i < 200 && !fired; i++) begin
        @(negedge clk);
        if (ready_in) begin
          fired = 1'b1;
          if (b == 0) first_acc = cyc;
        end
        @(posedge clk); #1;
      end
      if (!fired) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic expect_out(input string tag);
    for (int i = 0; i < 100 && q_out.size() < en; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_count"}, q_out.size(), en);
    for (int i = 0; i < en && i < q_out.size(); i++) begin
      $display("%s beat %0d: data=%h keep=%b last=%b", tag, i, q_out[i][31:0], q_out[i][35:32], q_out[i][36]);
      check($sformatf("%s_b%0d_data", tag, i), q_out[i][31:0], ed[i]);
      check($sformatf("%s_b%0d_keep", tag, i), q_out[i][35:32], ek[i]);
      check($sformatf("%s_b%0d_last", tag, i), q_out[i][36], el[i]);
    end
    q_out.delete();
    q_cyc.delete();
    @(posedge clk); #1;
  endtask

  task automatic load_pkt_a(input logic [3:0] last_keep);
    set_in(0, 32'hA1A2A3A4, 4'b1111);
    set_in(1, 32'hB1B2B3B4, 4'b1111);
    set_in(2, 32'hC1C2C3C4, last_keep);
  endtask

  task automatic exp_h3();
    set_exp(0, 32'h020304A1, 4'b1111, 1'b0);
    set_exp(1, 32'hA2A3A4B1, 4'b1111, 1'b0);
    set_exp(2, 32'hB2B3B4C1, 4'b1111, 1'b0);
    set_exp(3, 32'hC2000000, 4'b1000, 1'b1);
  endtask

  task automatic exp_h1();
    set_exp(0, 32'h04A1A2A3, 4'b1111, 1'b0);
    set_exp(1, 32'hA4B1B2B3, 4'b1111, 1'b0);
    set_exp(2, 32'hB4C10000, 4'b1100, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_keep_out"}, keep_out, 0);
    check({tag, "_last_out"}, last_out, 0);
    check({tag, "_ready_in"}, ready_in, 0);
    check({tag, "_ready_insert"}, ready_insert, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rel_ready_insert", ready_insert, 1);
    @(posedge clk); #1;

    // H=3
    load_pkt_a(4'b1100); exp_h3();
    send_header(32'h01020304, 4'b0111); send_pkt(); expect_out("s1");

    // H=1
    load_pkt_a(4'b1000); exp_h1();
    send_header(32'h01020304, 4'b0001); send_pkt(); expect_out("s2");

    // H=0: passthrough with one cycle latency
    load_pkt_a(4'b1100);
    set_exp(0, 32'hA1A2A3A4, 4'b1111, 1'b0);
    set_exp(1, 32'hB1B2B3B4, 4'b1111, 1'b0);
    set_exp(2, 32'hC1C20000, 4'b1100, 1'b1);
    send_header(32'h01020304, 4'b0000); send_pkt();
    for (int i = 0; i < 100 && q_cyc.size() == 0; i++) @(negedge clk);
    check("s3_latency", (q_cyc.size() > 0) ? 64'(q_cyc[0] - first_acc) : 64'd0, 1);
    expect_out("s3");

    // Data presented before the header must stall
    load_pkt_a(4'b1100); exp_h3();
    fork
      send_pkt();
      begin
        repeat (3) begin
          @(negedge clk);
          check("s4_ready_in_stall", ready_in, 0);
        end
        @(posedge clk); #1;
        send_header(32'h01020304, 4'b0111);
      end
    join
    expect_out("s4");

    // Downstream stall mid-packet
    load_pkt_a(4'b1100); exp_h3();
    ready_out = 1'b0;
    s5_done = 1'b0;
    fork
      begin
        send_header(32'h01020304, 4'b0111);
        send_pkt();
        s5_done = 1'b1;
      end
    join_none
    repeat (4) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      check("s5_hold_valid", valid_out, 1);
      check("s5_hold_data", data_out, 32'h020304A1);
      check("s5_hold_keep", keep_out, 4'b1111);
      check("s5_ready_in", ready_in, 0);
      check("s5_ready_insert", ready_insert, 0);
    end
    @(posedge clk); #1; ready_out = 1'b1;
    for (int i = 0; i < 300 && !s5_done; i++) @(negedge clk);
    check("s5_driver_done", s5_done, 1);
    expect_out("s5");
    @(negedge clk);
    check("s5_ready_insert_after", ready_insert, 1);
    @(posedge clk); #1;

    // H=4: header beat goes out first
    set_in(0, 32'hA1A2A3A4, 4'b1110);
    set_exp(0, 32'h01020304, 4'b1111, 1'b0);
    set_exp(1, 32'hA1A2A300, 4'b1110, 1'b1);
    send_header(32'h01020304, 4'b1111); send_pkt(); expect_out("s6");

    // Empty last beat with residual bytes pending
    set_in(0, 32'hA1A2A3A4, 4'b1111);
    set_in(1, 32'hDEADBEEF, 4'b0000);
    set_exp(0, 32'hAABBA1A2, 4'b1111, 1'b0);
    set_exp(1, 32'hA3A40000, 4'b1100, 1'b1);
    send_header(32'h0000AABB, 4'b0011); send_pkt(); expect_out("s7a");

    // Empty last beat with nothing pending still marks the boundary
    set_in(0, 32'h12345678, 4'b0000);
    set_exp(0, 32'h00000000, 4'b0000, 1'b1);
    send_header(32'h01020304, 4'b0000); send_pkt(); expect_out("s7b");

    // Reset mid-packet, then a fresh packet
    send_header(32'h01020304, 4'b0111);
    valid_in = 1'b1; data_in = 32'hA1A2A3A4; keep_in = 4'b1111; last_in = 1'b0;
    @(negedge clk);
    check("s8_ready_in", ready_in, 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("s8_rst");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("s8_rel_ready_insert", ready_insert, 1);
    @(posedge clk); #1;
    q_out.delete(); q_cyc.delete();
    load_pkt_a(4'b1000); exp_h1();
    send_header(32'h01020304, 4'b0001); send_pkt(); expect_out("s8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
